// File: rtl/wishbone_timer_responder_if.sv
// ----------------------------------------------------------------------------
// wishbone_if
// Wishbone bus bundle between a primary (initiator) and a secondary
// (responder).
//   cyc, stb  : bus cycle valid / request strobe (primary -> secondary)
//   we        : 1 = write, 0 = read
//   sel       : byte-lane enables for writes
//   addr      : byte address
//   dat_i_s   : write data into the secondary
//   tgd       : data tag (carried, not interpreted by the timer block)
//   dat_o_s   : read data out of the secondary
//   ack       : transfer acknowledge from the secondary
// ----------------------------------------------------------------------------
interface wishbone_if #(
  parameter int DATA_SIZE = 64,
  parameter int BYTE_NUM  = DATA_SIZE / 8
);
  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [BYTE_NUM-1:0]  sel;
  logic [63:0]          addr;
  logic [DATA_SIZE-1:0] dat_i_s;
  logic                 tgd;
  logic [DATA_SIZE-1:0] dat_o_s;
  logic                 ack;

  modport primary (
    output cyc, stb, we, sel, addr, dat_i_s, tgd,
    input  dat_o_s, ack
  );

  modport secondary (
    input  cyc, stb, we, sel, addr, dat_i_s, tgd,
    output dat_o_s, ack
  );
endinterface

// File: rtl/wishbone_timer_responder.sv
// ----------------------------------------------------------------------------
// wishbone_timer_responder
// Machine-timer register block (msip, mtime, mtimecmp) as a Wishbone
// responder. One registered ack per request, byte-enabled writes, and
// registered timer / software interrupt outputs for the core.
//   clock     : system clock, rising edge
//   reset_n   : asynchronous active-low reset
//   wish_s    : Wishbone secondary port (offset decoded from addr[4:3])
//               0 = msip (bit 0), 1 = mtime, 2 = mtimecmp, 3 = reserved
//   timer_irq : mtime >= mtimecmp (unsigned), registered
//   soft_irq  : msip bit 0, registered
// Only DATA_SIZE = 64 is supported.
// ----------------------------------------------------------------------------
module wishbone_timer_responder #(
  parameter int          DATA_SIZE      = 64,
  parameter int          BYTE_NUM       = DATA_SIZE / 8,
  parameter int          CLOCK_DIV      = 4,
  parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic          clock,
  input  logic          reset_n,
  wishbone_if.secondary wish_s,
  output logic          timer_irq,
  output logic          soft_irq
);

  localparam int PRESC_W = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLOCK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state_r, state_next_s;
  logic                 ack_r, ack_next_s;
  logic [63:0]          dat_o_r, dat_o_next_s;
  logic [63:0]          mtime_r, mtime_next_s, mtime_inc_s;
  logic [63:0]          mtimecmp_r, mtimecmp_next_s;
  logic                 msip_r, msip_next_s;
  logic [PRESC_W-1:0]   presc_r, presc_next_s;
  logic                 timer_irq_r, soft_irq_r;
  logic                 req_s, access_s, wr_s, tick_s;
  logic [1:0]           offset_s;
  logic [63:0]          read_val_s;
  logic                 unused_s;

  // Replace only the byte lanes enabled in be with the new value.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  be);
    logic [63:0] res;
    res = old_v;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) begin
        res[i*8 +: 8] = new_v[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = old_v[i*8 +: 8];
      end
    end
    return res;
  endfunction

  assign req_s    = wish_s.cyc & wish_s.stb;
  assign offset_s = wish_s.addr[4:3];
  assign tick_s   = (presc_r == PRESC_MAX);
  assign wr_s     = access_s & wish_s.we;
  // Address bits outside the register window and the tag are not decoded.
  assign unused_s = ^{wish_s.tgd, wish_s.addr[63:5], wish_s.addr[2:0]};

  // Read multiplexer over the current (pre-edge) register values.
  always_comb begin
    read_val_s = 64'd0;
    case (offset_s)
      2'd0:    read_val_s = {63'd0, msip_r};
      2'd1:    read_val_s = mtime_r;
      2'd2:    read_val_s = mtimecmp_r;
      default: read_val_s = 64'd0;
    endcase
  end

  // Bus FSM next state: accept only from IDLE, so a held strobe is acked once.
  always_comb begin
    state_next_s = state_r;
    ack_next_s   = 1'b0;
    dat_o_next_s = 64'd0;
    access_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          state_next_s = ACK;
          ack_next_s   = 1'b1;
          access_s     = 1'b1;
          dat_o_next_s = wish_s.we ? 64'd0 : read_val_s;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACK: begin
        if (req_s) begin
          state_next_s = HOLD;
        end else begin
          state_next_s = IDLE;
        end
      end
      HOLD: begin
        if (req_s) begin
          state_next_s = HOLD;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Timer register next values; a write merges over the already-ticked mtime.
  always_comb begin
    presc_next_s    = tick_s ? {PRESC_W{1'b0}} : presc_r + {{(PRESC_W-1){1'b0}}, 1'b1};
    mtime_inc_s     = tick_s ? mtime_r + 64'd1 : mtime_r;
    mtime_next_s    = mtime_inc_s;
    mtimecmp_next_s = mtimecmp_r;
    msip_next_s     = msip_r;
    if (wr_s) begin
      case (offset_s)
        2'd0: begin
          if (wish_s.sel[0]) begin
            msip_next_s = wish_s.dat_i_s[0];
          end else begin
            msip_next_s = msip_r;
          end
        end
        2'd1:    mtime_next_s    = merge_bytes(mtime_inc_s, wish_s.dat_i_s, wish_s.sel);
        2'd2:    mtimecmp_next_s = merge_bytes(mtimecmp_r, wish_s.dat_i_s, wish_s.sel);
        default: mtime_next_s    = mtime_inc_s;
      endcase
    end else begin
      mtime_next_s = mtime_inc_s;
    end
  end

  // Bus FSM state and registered response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      ack_r   <= 1'b0;
      dat_o_r <= 64'd0;
    end else begin
      state_r <= state_next_s;
      ack_r   <= ack_next_s;
      dat_o_r <= dat_o_next_s;
    end
  end

  // Timer registers and prescaler.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_r    <= {PRESC_W{1'b0}};
      mtime_r    <= 64'd0;
      mtimecmp_r <= MTIMECMP_RESET;
      msip_r     <= 1'b0;
    end else begin
      presc_r    <= presc_next_s;
      mtime_r    <= mtime_next_s;
      mtimecmp_r <= mtimecmp_next_s;
      msip_r     <= msip_next_s;
    end
  end

  // Interrupts follow the register state with one cycle of delay.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_irq_r <= 1'b0;
      soft_irq_r  <= 1'b0;
    end else begin
      timer_irq_r <= (mtime_r >= mtimecmp_r);
      soft_irq_r  <= msip_r;
    end
  end

  assign wish_s.ack     = ack_r;
  assign wish_s.dat_o_s = dat_o_r;
  assign timer_irq      = timer_irq_r;
  assign soft_irq       = soft_irq_r;

endmodule

// File: tb/tb_wishbone_timer_responder.sv
// ----------------------------------------------------------------------------
// tb_wishbone_timer_responder
// Self-checking bench: a transaction-level model of the timer block is
// stepped on every rising edge and a compare process checks ack, dat_o_s,
// timer_irq and soft_irq on every falling edge. Directed scenarios add
// literal expectations, followed by randomized bus traffic.
// ----------------------------------------------------------------------------
module tb_wishbone_timer_responder;

  localparam int CLOCK_DIV = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic timer_irq;
  logic soft_irq;

  int n_checks = 0;
  int n_errors = 0;

  wishbone_if #(.DATA_SIZE(64)) bus ();

  wishbone_timer_responder #(
    .DATA_SIZE(64),
    .CLOCK_DIV(CLOCK_DIV),
    .MTIMECMP_RESET(64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .wish_s(bus),
    .timer_irq(timer_irq),
    .soft_irq(soft_irq)
  );

  always #5 clock = ~clock;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [63:0] m_mtime = 64'd0;
  logic [63:0] m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
  logic        m_msip  = 1'b0;
  int unsigned m_edges = 0;   // rising edges since reset release
  bit          m_armed = 1'b1; // a new request may be accepted
  logic        exp_ack = 1'b0;
  logic [63:0] exp_dat = 64'd0;
  logic        exp_tirq = 1'b0;
  logic        exp_sirq = 1'b0;

  task automatic model_step();
    logic        req;
    logic [63:0] nt, rd, mask;
    if (!reset_n) begin
      m_mtime = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_msip = 1'b0;
      m_edges = 0; m_armed = 1'b1;
      exp_ack = 1'b0; exp_dat = 64'd0; exp_tirq = 1'b0; exp_sirq = 1'b0;
    end else begin
      req = bus.cyc && bus.stb;
      exp_tirq = (m_mtime >= m_cmp);
      exp_sirq = m_msip;
      nt = m_mtime;
      if ((m_edges % CLOCK_DIV) == (CLOCK_DIV - 1)) nt = m_mtime + 64'd1;
      m_edges++;
      exp_ack = 1'b0;
      exp_dat = 64'd0;
      if (req && m_armed) begin
        m_armed = 1'b0;
        exp_ack = 1'b1;
        mask = 64'd0;
        for (int b = 0; b < 8; b++) if (bus.sel[b]) mask[b*8 +: 8] = 8'hFF;
        case (bus.addr[4:3])
          2'd0: rd = {63'd0, m_msip};
          2'd1: rd = m_mtime;
          2'd2: rd = m_cmp;
          default: rd = 64'd0;
        endcase
        if (bus.we) begin
          case (bus.addr[4:3])
            2'd0: if (bus.sel[0]) m_msip = bus.dat_i_s[0];
            2'd1: nt = (nt & ~mask) | (bus.dat_i_s & mask);
            2'd2: m_cmp = (m_cmp & ~mask) | (bus.dat_i_s & mask);
            default: ;
          endcase
        end else begin
          exp_dat = rd;
        end
      end else if (!req) begin
        m_armed = 1'b1;
      end
      m_mtime = nt;
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // Compare process: outputs are stable at the falling edge.
  initial forever begin
    @(negedge clock);
    check("ack", 64'(bus.ack), 64'(exp_ack));
    check("dat_o_s", bus.dat_o_s, exp_dat);
    check("timer_irq", 64'(timer_irq), 64'(exp_tirq));
    check("soft_irq", 64'(soft_irq), 64'(exp_sirq));
  end

  // ---------------- directed helpers ----------------
  // Called at a falling edge; returns one idle cycle after the ack.
  task automatic xfer(input bit we, input logic [63:0] addr, input logic [63:0] data,
                      input logic [7:0] sel, output logic [63:0] rdata);
    bit got;
    int lat;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we; bus.addr = addr;
    bus.dat_i_s = data; bus.sel = sel;
    got = 1'b0; lat = 0; rdata = 64'd0;
    for (int i = 0; i < 4; i++) begin
      if (!got) begin
        @(negedge clock);
        if (bus.ack) begin got = 1'b1; rdata = bus.dat_o_s; lat = i + 1; end
      end
    end
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    check("ack_seen", 64'(got), 64'd1);
    check("ack_latency", 64'(lat), 64'd1);
    @(negedge clock);
  endtask

  initial begin
    logic [63:0] rd;
    int acks;
    bit seen;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.sel = 8'd0;
    bus.addr = 64'd0; bus.dat_i_s = 64'd0; bus.tgd = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // reset value of mtimecmp
    xfer(1'b0, 64'h10, 64'd0, 8'h00, rd);
    check("mtimecmp_reset", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    check("timer_irq_reset", 64'(timer_irq), 64'd0);

    // mtime counts one per CLOCK_DIV cycles from a fresh reset
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    xfer(1'b0, 64'h08, 64'd0, 8'h00, rd);
    check("mtime_after_40", 64'(rd >= 64'd9 && rd <= 64'd11), 64'd1);

    // reset mid-request drops the transaction
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.addr = 64'h08;
    #2 reset_n = 1'b0;
    acks = 0;
    @(negedge clock); if (bus.ack) acks++;
    bus.cyc = 1'b0; bus.stb = 1'b0;
    @(negedge clock); if (bus.ack) acks++;
    reset_n = 1'b1;
    repeat (2) begin @(negedge clock); if (bus.ack) acks++; end
    check("ack_dropped_by_reset", 64'(acks), 64'd0);
    xfer(1'b0, 64'h08, 64'd0, 8'h00, rd);
    check("mtime_after_reset", rd, 64'd0);

    // timer interrupt raise and clear
    xfer(1'b1, 64'h10, 64'h20, 8'hFF, rd);
    xfer(1'b1, 64'h08, 64'h1E, 8'hFF, rd);
    seen = timer_irq;
    for (int i = 0; i < 2 * CLOCK_DIV + 3; i++) begin
      if (!seen) begin @(negedge clock); seen = timer_irq; end
    end
    check("timer_irq_rise", 64'(seen), 64'd1);
    xfer(1'b1, 64'h10, 64'h100, 8'hFF, rd);
    check("timer_irq_clear", 64'(timer_irq), 64'd0);

    // software interrupt
    xfer(1'b1, 64'h00, 64'h1, 8'hFF, rd);
    check("soft_irq_set", 64'(soft_irq), 64'd1);
    xfer(1'b1, 64'h00, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd);
    check("soft_irq_clear", 64'(soft_irq), 64'd0);
    xfer(1'b0, 64'h00, 64'd0, 8'h00, rd);
    check("msip_readback", rd, 64'd0);

    // byte-enabled partial writes
    xfer(1'b1, 64'h10, 64'h1122_3344_5566_7788, 8'hFF, rd);
    xfer(1'b1, 64'h10, 64'h0000_0000_0000_AA00, 8'h02, rd);
    xfer(1'b0, 64'h10, 64'd0, 8'h00, rd);
    check("mtimecmp_byte_write", rd, 64'h1122_3344_5566_AA88);
    xfer(1'b1, 64'h08, 64'h1122_3344_5566_7788, 8'hFF, rd);
    xfer(1'b1, 64'h08, 64'h0000_0000_0000_AA00, 8'h02, rd);
    xfer(1'b0, 64'h08, 64'd0, 8'h00, rd);
    check("mtime_byte_write", 64'(rd[63:8]), 64'h0011_2233_4455_66AA);
    xfer(1'b1, 64'h10, 64'h1234, 8'h00, rd);
    xfer(1'b0, 64'h10, 64'd0, 8'h00, rd);
    check("sel_zero_no_change", rd, 64'h1122_3344_5566_AA88);

    // strobe held for 5 cycles gives a single ack
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.addr = 64'h08;
    acks = 0;
    repeat (5) begin @(negedge clock); if (bus.ack) acks++; end
    bus.cyc = 1'b0; bus.stb = 1'b0;
    @(negedge clock); if (bus.ack) acks++;
    check("single_ack_held_stb", 64'(acks), 64'd1);

    // mtime wraps modulo 2^64
    xfer(1'b1, 64'h08, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd);
    repeat (CLOCK_DIV) @(negedge clock);
    xfer(1'b0, 64'h08, 64'd0, 8'h00, rd);
    check("mtime_wrap", 64'(rd <= 64'd2), 64'd1);

    // reserved offset
    xfer(1'b1, 64'h18, 64'hDEAD_BEEF, 8'hFF, rd);
    xfer(1'b0, 64'h18, 64'd0, 8'h00, rd);
    check("reserved_reads_zero", rd, 64'd0);

    // randomized traffic checked by the model
    for (int k = 0; k < 300; k++) begin
      bus.cyc = 1'b1;
      bus.stb = ($urandom_range(0, 7) != 0);
      bus.we = $urandom_range(0, 1);
      bus.addr = {$urandom(), $urandom()};
      bus.sel = 8'($urandom());
      if ($urandom_range(0, 1) == 0) bus.dat_i_s = 64'($urandom_range(0, 255));
      else bus.dat_i_s = {$urandom(), $urandom()};
      bus.tgd = 1'($urandom());
      repeat ($urandom_range(1, 4)) @(negedge clock);
      bus.cyc = 1'b0; bus.stb = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wishbone_timer_responder.md
Name: wishbone_timer_responder

Overview:
- Wishbone secondary (responder) implementing the machine-timer register block (msip, mtime, mtimecmp).
- Sits at the CSR region of the memory map, on the wish_p_csr primary leg of the memory controller.
- Produces the machine timer and software interrupt lines for the core.
- Single-cycle registered response; one ack per request; supports byte-enabled writes.

Parameters:
- DATA_SIZE, 64, data bus width in bits; only 64 is supported.
- BYTE_NUM, DATA_SIZE/8, number of byte-select lanes.
- CLOCK_DIV, 4, clock cycles per mtime increment; must be >= 1.
- MTIMECMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wish_s  wishbone_if.secondary  -  bus port; members used:
  - cyc  in  1  bus cycle valid.
  - stb  in  1  request strobe.
  - we  in  1  1 = write, 0 = read.
  - sel  in  BYTE_NUM  byte enables for writes.
  - addr  in  64  byte address; only addr[4:3] is decoded.
  - dat_i_s  in  DATA_SIZE  write data.
  - tgd  in  1  ignored.
  - dat_o_s  out  DATA_SIZE  read data.
  - ack  out  1  transfer acknowledge.
- timer_irq  output  1  machine timer interrupt pending.
- soft_irq  output  1  machine software interrupt pending.

Behaviour:
- Reset (reset_n low, asynchronous):
  - ack = 0, dat_o_s = 0, FSM = IDLE.
  - mtime = 0, prescaler = 0, mtimecmp = MTIMECMP_RESET, msip = 0.
  - timer_irq = 0, soft_irq = 0.
  - A transaction in flight is dropped; no ack follows release of reset.
- Register map (offset = addr[4:3]):
  - 0: msip. Bit 0 is writable, all other bits read 0.
  - 1: mtime. Read/write, 64-bit.
  - 2: mtimecmp. Read/write, 64-bit.
  - 3: reserved. Reads 0, writes ignored, still acked.
- FSM states IDLE, ACK, HOLD:
  - IDLE: when cyc & stb, perform the access at this clock edge and go to ACK. The next cycle carries ack = 1 and dat_o_s = read value, or 0 for writes.
  - ACK: ack is high for exactly one cycle. If cyc & stb are still high, go to HOLD; otherwise go to IDLE.
  - HOLD: ack = 0 until stb or cyc drops, then go to IDLE. A new request needs stb to deassert first.
  - Latency: request seen in cycle N gives ack in cycle N+1.
- Writes:
  - Byte lane i is updated only if sel[i] = 1.
  - sel = 0 still acks with no state change.
- Reads:
  - The value sampled in the request cycle is held on dat_o_s while ack = 1.
  - dat_o_s returns to 0 in IDLE and HOLD.
- mtime counting:
  - The prescaler counts 0..CLOCK_DIV-1. mtime increments by 1 when the prescaler wraps to 0.
  - mtime wraps modulo 2^64 (all-ones + 1 = 0).
  - An mtime write in the same cycle as a tick: the written bytes take the write data, unwritten bytes take the incremented value. The prescaler is not reset.
- Interrupts (both registered, one cycle after the state that causes them):
  - timer_irq = (mtime >= mtimecmp), unsigned compare.
  - Rewriting mtimecmp to a value above mtime clears timer_irq on the following cycle.
  - soft_irq = msip[0].

Test Plan:
- Reset, then read offset 2 (addr 0x10) -> ack exactly 1 cycle after the request, dat_o_s = 0xFFFF_FFFF_FFFF_FFFF; timer_irq = 0.
- Hold reset_n high for 40 cycles with CLOCK_DIV = 4, then read mtime -> 10 (±1 depending on sample edge). Deassert reset_n mid-request -> ack never asserts, mtime = 0.
- Write mtimecmp = 0x20 with sel = 0xFF, then write mtime = 0x1E -> timer_irq rises within 2 ticks + 1 cycle. Write mtimecmp = 0x100 -> timer_irq = 0 one cycle after the ack.
- Write 0x1 to offset 0 -> soft_irq = 1. Write 0xFFFF_FFFF_FFFF_FFFE -> soft_irq = 0, readback = 0.
- Byte-enable partial write: mtime = 0x1122_3344_5566_7788 (paused by a large CLOCK_DIV), write 0xAA00 with sel = 0x02 -> readback 0x1122_3344_5566_AA88.
- Hold stb high for 5 cycles -> exactly one ack pulse. Write mtime = 0xFFFF_FFFF_FFFF_FFFF -> wraps to 0 after CLOCK_DIV cycles. Access offset 3 -> acked, reads 0.
